fifo_word_packer: RTL

- Downstream consumer of the synchronous byte FIFO.
- Pops IN_W-bit entries from the FIFO read port, packs RATIO consecutive entries into one wide word, and presents it on a valid/ready master interface.
- A flush request emits a partial word with a lane-keep mask.
- Handles the FIFO's registered read: read data is valid the cycle after pop.

---
 rtl/fifo_word_packer.sv | 91 +++++++++
 1 files changed

// File: rtl/fifo_word_packer.sv
// Packs RATIO consecutive IN_W-bit entries from a registered-read FIFO into one
// wide word on a valid/ready master port; a flush emits a partial word with a keep mask.
module fifo_word_packer #(
    parameter int IN_W  = 8,
    parameter int RATIO = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_pop,
    input  logic [IN_W-1:0]       fifo_data,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [IN_W*RATIO-1:0] m_data,
    output logic [RATIO-1:0]      m_keep
);

    localparam int              CW        = $clog2(RATIO + 1);
    localparam int              OW        = IN_W * RATIO;
    localparam logic [CW-1:0]   CNT_FULL  = CW'(RATIO);
    localparam logic [CW:0]     RATIO_EXT = (CW + 1)'(RATIO);

    logic [OW-1:0]    acc;
    logic [CW-1:0]    cnt;
    logic             pop_q;
    logic             flush_pending;
    logic [CW:0]      fill_sum;
    logic             out_free;
    logic             full_xfer;
    logic             flush_xfer;
    logic             flush_drop;
    logic [RATIO-1:0] part_keep;

    // Lanes already filled plus the one still in flight; one extra bit so it never wraps.
    assign fill_sum = {1'b0, cnt} + {{CW{1'b0}}, pop_q};
    assign fifo_pop = !rst && !fifo_empty && !flush_pending && (fill_sum < RATIO_EXT);

    assign out_free   = !m_valid || m_ready;
    assign full_xfer  = (cnt == CNT_FULL) && out_free;
    assign flush_xfer = flush_pending && !pop_q && (cnt != '0) && (cnt != CNT_FULL) && out_free;
    assign flush_drop = flush_pending && !pop_q && (cnt == '0);

    // NOTE: every bit gets a value on every pass through the loop, so no latch is inferred.
    always_comb begin
        part_keep = '0;
        for (int i = 0; i < RATIO; i++) begin
            part_keep[i] = (CW'(i) < cnt);
        end
    end

    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc           <= '0;
            cnt           <= '0;
            pop_q         <= 1'b0;
            flush_pending <= 1'b0;
            m_valid       <= 1'b0;
            m_data        <= '0;
            m_keep        <= '0;
        end else begin
            pop_q <= fifo_pop;
            if (flush && !flush_pending) begin
                flush_pending <= 1'b1;
            end

            if (full_xfer || flush_xfer) begin
                m_data        <= acc;
                m_keep        <= full_xfer ? {RATIO{1'b1}} : part_keep;
                m_valid       <= 1'b1;
                cnt           <= '0;
                acc           <= '0;
                flush_pending <= 1'b0;
            end else begin
                if (m_valid && m_ready) begin
                    m_valid <= 1'b0;
                end
                // A capture lands here even while flush is pending, so the flushed word includes it.
                if (pop_q) begin
                    acc[int'(cnt)*IN_W +: IN_W] <= fifo_data;
                    cnt                          <= cnt + 1'b1;
                end
                if (flush_drop) begin
                    flush_pending <= 1'b0;
                end
            end
        end
    end

endmodule
